// File: rtl/pri_irq_pkg.sv
// pri_irq_pkg: shared definitions for the priority interrupt controller.
//   state_t   - arbitration FSM states (IDLE, ASSERT, WAIT_REL)
//   PRI_MAX_N - largest supported channel count
package pri_irq_pkg;

    localparam int PRI_MAX_N = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

endpackage

// File: rtl/pri_enc.sv
// pri_enc: combinational highest-set-bit finder.
// Ports:
//   vec   in  [N-1:0]  candidate vector
//   idx   out [W-1:0]  index of the highest set bit (0 when none set)
//   valid out          1 when any bit of vec is set
module pri_enc #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Ascending scan: the last set bit seen is the highest, so it wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx   = W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pri_irq_ctrl.sv
// pri_irq_ctrl: fixed-priority interrupt controller with a four-phase
// grant/acknowledge handshake and cascade enable-out.
//
// Build option: define PRI_IRQ_CTRL_EDGE_EN to capture requests on falling
// edges of In (history register); otherwise requests are level-captured.
//
// Ports:
//   CLK       in           rising-edge clock
//   RST       in           synchronous active-high reset
//   EI        in           active-low enable
//   In        in  [N-1:0]  active-low request lines
//   Mask      in  [N-1:0]  1 = channel excluded from arbitration
//   Ack       in           active-high acknowledge
//   Out       out [W-1:0]  active-low encoded index of granted channel
//   GS        out          active-low grant valid
//   EO        out          active-low cascade enable-out
//   Pend      out [N-1:0]  pending-request register
//   dbg_state out          current FSM state
//
// Handshake: GS falls (with Out valid) when a grant is made; Out is frozen
// until the consumer raises Ack. The Ack-high edge retires the grant and
// clears its pending bit; the controller then waits for Ack to fall before
// it can arbitrate again. Ack is ignored outside these two phases.
module pri_irq_ctrl
    import pri_irq_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EI,
    input  logic [N-1:0] In,
    input  logic [N-1:0] Mask,
    input  logic         Ack,
    output logic [W-1:0] Out,
    output logic         GS,
    output logic         EO,
    output logic [N-1:0] Pend,
    output state_t       dbg_state
);

    if (N < 2 || N > PRI_MAX_N) begin : g_bad_n
        $error("pri_irq_ctrl: N must be in 2..%0d", PRI_MAX_N);
    end

    state_t         state_q, state_d;
    logic [W-1:0]   gidx_q, gidx_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   set_vec;
    logic [N-1:0]   clr_vec;
    logic [W-1:0]   enc_idx;
    logic           enc_valid;
    logic [W-1:0]   out_q;
    logic           gs_q;
    logic           eo_q;

`ifdef PRI_IRQ_CTRL_EDGE_EN
    // Previous sample of In; reset to idle-high so a line already low at
    // reset release does count as a falling edge only if it was seen high.
    logic [N-1:0] hist_q;

    always_ff @(posedge CLK) begin
        if (RST) hist_q <= '1;
        else     hist_q <= In;
    end

    assign set_vec = EI ? '0 : (hist_q & ~In);
`else
    assign set_vec = EI ? '0 : ~In;
`endif

    pri_enc #(.N(N), .W(W)) u_enc (
        .vec   (pend_q & ~Mask),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        clr_vec = '0;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d = ASSERT;
                    gidx_d  = enc_idx;
                end
            end
            ASSERT: begin
                // Grant is held regardless of Mask or newer requests.
                if (Ack) begin
                    state_d         = WAIT_REL;
                    clr_vec[gidx_q] = 1'b1;
                end
            end
            WAIT_REL: begin
                if (!Ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (EI) state_d = IDLE;
        // Set is OR-ed after the clear so a same-cycle re-request survives.
        pend_d = EI ? '0 : ((pend_q & ~clr_vec) | set_vec);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            pend_q  <= '0;
            out_q   <= '1;
            gs_q    <= 1'b1;
            eo_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            pend_q  <= pend_d;
            out_q   <= (state_d == ASSERT) ? ~gidx_d : '1;
            gs_q    <= (state_d != ASSERT);
            eo_q    <= !(!EI && (state_d == IDLE) && ((pend_d & ~Mask) == '0));
        end
    end

    assign Out       = out_q;
    assign GS        = gs_q;
    assign EO        = eo_q;
    assign Pend      = pend_q;
    assign dbg_state = state_q;

endmodule
